// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
package mem_arb_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef enum logic {
        OWN_A,
        OWN_B
    } owner_t;

endpackage

// File: rtl/mem_arb_ram.sv
// rtl/mem_arb_ram.sv - plain 1W1R synchronous-read memory, unreset array
module mem_arb_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_arb_2p.sv
// rtl/mem_arb_2p.sv - round-robin two-client arbiter in front of one 1W1R memory
// Optional post-reset clear sweep enabled by MEM_ARB_INIT_CLEAR_EN.
module mem_arb_2p
    import mem_arb_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          busy
);

    state_t        state_q;
    owner_t        last_q;
    logic          sweep_we;
    logic [AW-1:0] sweep_addr;

    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] a_hold;
    logic [DW-1:0] b_hold;

`ifdef MEM_ARB_INIT_CLEAR_EN
    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state_d;
    logic [AW-1:0] sweep_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            // Counter parks on the last address instead of wrapping.
            if (state_q == ST_INIT && sweep_q != LAST_ADDR) begin
                sweep_q <= sweep_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (sweep_q == LAST_ADDR) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign sweep_we   = (state_q == ST_INIT);
    assign sweep_addr = sweep_q;
`else
    assign state_q    = ST_RUN;
    assign sweep_we   = 1'b0;
    assign sweep_addr = '0;
`endif

    assign busy = (state_q == ST_INIT);

    // On a tie the requester that did not win last time takes the port.
    assign a_gnt = (state_q == ST_RUN) && a_req && (!b_req || last_q == OWN_B);
    assign b_gnt = (state_q == ST_RUN) && b_req && (!a_req || last_q == OWN_A);

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_waddr = '0;
        mem_raddr = '0;
        mem_wdata = '0;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_addr;
        end else if (a_gnt) begin
            mem_we    = a_we;
            mem_re    = !a_we;
            mem_waddr = a_addr;
            mem_raddr = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_re    = !b_we;
            mem_waddr = b_addr;
            mem_raddr = b_addr;
            mem_wdata = b_wdata;
        end
    end

    mem_arb_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= OWN_B;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_hold   <= '0;
            b_hold   <= '0;
        end else begin
            if (a_gnt) begin
                last_q <= OWN_A;
            end else if (b_gnt) begin
                last_q <= OWN_B;
            end
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
            if (a_rvalid) a_hold <= mem_rdata;
            if (b_rvalid) b_hold <= mem_rdata;
        end
    end

    // The shared RAM output register belongs to whichever owner is tagged valid.
    assign a_rdata = a_rvalid ? mem_rdata : a_hold;
    assign b_rdata = b_rvalid ? mem_rdata : b_hold;

endmodule
